// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants and types for the inverted-Hamming (39,32) SECDED code.
//   secded_39_32_t : 39-bit codeword, [31:0] data, [38:32] check bits.
//   SecdedMask0..5 : data-bit participation masks for check bits c0..c5.
//   SecdedInv      : inversion pattern (bits 33, 35, 37) so that all-zero data
//                    never produces an all-zero codeword.
package ecc_pkg;

    typedef logic [38:0] secded_39_32_t;

    localparam logic [31:0] SecdedMask0 = 32'h56aaad5b;
    localparam logic [31:0] SecdedMask1 = 32'h9b33366d;
    localparam logic [31:0] SecdedMask2 = 32'he3c3c78e;
    localparam logic [31:0] SecdedMask3 = 32'h03fc07f0;
    localparam logic [31:0] SecdedMask4 = 32'h03fff800;
    localparam logic [31:0] SecdedMask5 = 32'hfc000000;

    localparam secded_39_32_t SecdedInv = 39'h2a00000000;

endpackage

// File: rtl/prim_secded_inv_hamming_39_32_enc.sv
// prim_secded_inv_hamming_39_32_enc: purely combinational 32->39 inverted-Hamming encoder.
//   data_i : 32-bit data word.
//   data_o : 39-bit codeword {c6, c[5:0], data} with the inversion pattern applied.
module prim_secded_inv_hamming_39_32_enc
    import ecc_pkg::*;
(
    input  logic [31:0]   data_i,
    output secded_39_32_t data_o
);

    logic [5:0] chk;
    logic       par;

    always_comb begin
        chk[0] = ^(data_i & SecdedMask0);
        chk[1] = ^(data_i & SecdedMask1);
        chk[2] = ^(data_i & SecdedMask2);
        chk[3] = ^(data_i & SecdedMask3);
        chk[4] = ^(data_i & SecdedMask4);
        chk[5] = ^(data_i & SecdedMask5);
        // Overall parity covers the Hamming check bits as well as the data.
        par    = ^{chk, data_i};
        data_o = {par, chk, data_i} ^ SecdedInv;
    end

endmodule

// File: rtl/secded_inv_hamming_39_32_enc_pipe.sv
// secded_inv_hamming_39_32_enc_pipe: streaming SECDED encoder with a registered output stage
// and one skid entry. Words are encoded on acceptance, so both storage slots hold codewords.
//   clk_i, rst_ni            : clock, synchronous active-low reset.
//   in_valid_i/in_ready_o    : input handshake (in_ready_o registered), in_data_i 32-bit data.
//   out_valid_o/out_ready_i  : output handshake, out_data_o 39-bit codeword (registered).
//   inj_arm_i, inj_mask_i    : arm a one-shot XOR mask for the next accepted word.
//   inj_pending_o            : an armed mask is waiting for a word.
//   words_o                  : wrapping count of output handshakes (CntW bits).
// Optional feature macro: ECC_ENC_ERR_INJECT_EN enables error injection; otherwise the
// injection inputs are ignored and inj_pending_o is 0.
module secded_inv_hamming_39_32_enc_pipe
    import ecc_pkg::*;
#(
    parameter int unsigned CntW = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output secded_39_32_t       out_data_o,
    input  logic                inj_arm_i,
    input  logic [38:0]         inj_mask_i,
    output logic                inj_pending_o,
    output logic [CntW-1:0]     words_o
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e          state_q, state_d;
    secded_39_32_t   out_data_q, out_data_d;
    secded_39_32_t   skid_q, skid_d;
    logic            in_ready_q;
    logic [CntW-1:0] words_q, words_d;

    secded_39_32_t   enc_cw;
    secded_39_32_t   enc_word;
    logic            in_hs, out_hs;

    assign in_hs  = in_valid_i & in_ready_q;
    assign out_hs = out_valid_o & out_ready_i;

    prim_secded_inv_hamming_39_32_enc u_enc (
        .data_i (in_data_i),
        .data_o (enc_cw)
    );

`ifdef ECC_ENC_ERR_INJECT_EN
    logic [38:0] inj_mask_q;
    logic        inj_pending_q;

    // Only a mask that was already pending applies; a same-cycle arm waits for the next word.
    assign enc_word = (in_hs && inj_pending_q) ? (enc_cw ^ inj_mask_q) : enc_cw;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inj_mask_q    <= '0;
            inj_pending_q <= 1'b0;
        end else if (inj_arm_i) begin
            inj_mask_q    <= inj_mask_i;
            inj_pending_q <= 1'b1;
        end else if (in_hs) begin
            inj_pending_q <= 1'b0;
        end
    end

    assign inj_pending_o = inj_pending_q;
`else
    logic unused_inj;
    assign unused_inj    = ^{inj_arm_i, inj_mask_i};
    assign enc_word      = enc_cw;
    assign inj_pending_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        words_d    = out_hs ? words_q + CntW'(1) : words_q;
        unique case (state_q)
            StEmpty: begin
                if (in_hs) begin
                    state_d    = StOne;
                    out_data_d = enc_word;
                end
            end
            StOne: begin
                if (in_hs && out_hs) begin
                    out_data_d = enc_word;
                end else if (in_hs) begin
                    state_d = StTwo;
                    skid_d  = enc_word;
                end else if (out_hs) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready_q is low here, so only draining is possible.
                if (out_hs) begin
                    state_d    = StOne;
                    out_data_d = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
            words_q    <= words_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = out_data_q;
    assign words_o     = words_q;

endmodule

// File: tb/tb_secded_inv_hamming_39_32_enc_pipe.sv
// Self-checking bench for secded_inv_hamming_39_32_enc_pipe: directed cases plus random
// streaming checked against a queue-based model of the buffering and a formula-level encoder.
module tb_secded_inv_hamming_39_32_enc_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [38:0] out_data;
    logic        inj_arm;
    logic [38:0] inj_mask;
    logic        inj_pending;
    logic [31:0] words;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [38:0] exp_q[$];
    logic        m_ready;
    logic [31:0] m_words;
    logic        m_pend;
    logic [38:0] m_mask;

    always #5 clk = ~clk;

    secded_inv_hamming_39_32_enc_pipe #(.CntW(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .inj_arm_i     (inj_arm),
        .inj_mask_i    (inj_mask),
        .inj_pending_o (inj_pending),
        .words_o       (words)
    );

    function automatic logic [5:0] hamming_checks(logic [31:0] d);
        logic [31:0] masks [6];
        logic [5:0]  c;
        masks[0] = 32'h56aaad5b;
        masks[1] = 32'h9b33366d;
        masks[2] = 32'he3c3c78e;
        masks[3] = 32'h03fc07f0;
        masks[4] = 32'h03fff800;
        masks[5] = 32'hfc000000;
        for (int i = 0; i < 6; i++) c[i] = ^(d & masks[i]);
        return c;
    endfunction

    function automatic logic [38:0] ref_enc(logic [31:0] d);
        logic [5:0] c;
        c = hamming_checks(d);
        return {^{c, d}, c, d} ^ 39'h2a00000000;
    endfunction

    // Decoder-side view: {overall parity, Hamming syndrome}; all zero for a clean codeword.
    function automatic logic [6:0] syndrome(logic [38:0] cw);
        logic [38:0] x;
        x = cw ^ 39'h2a00000000;
        return {^x, hamming_checks(x[31:0]) ^ x[37:32]};
    endfunction

    // 00 clean, 01 single (odd parity), 10 double (nonzero syndrome, even parity)
    function automatic logic [1:0] err_class(logic [38:0] cw);
        logic [6:0] s;
        s = syndrome(cw);
        if (s == 7'd0) return 2'b00;
        if (s[6]) return 2'b01;
        return 2'b10;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the negedge, update the model at the posedge, then compare.
    task automatic step(input logic rst, input logic iv, input logic [31:0] d, input logic ordy,
                        input logic arm, input logic [38:0] m);
        logic        ihs, ohs;
        logic [38:0] w;
        rst_n     = rst;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        inj_arm   = arm;
        inj_mask  = m;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            m_ready = 1'b0;
            m_words = '0;
            m_pend  = 1'b0;
            m_mask  = '0;
        end else begin
            ihs = iv && m_ready;
            ohs = ordy && (exp_q.size() > 0);
            if (ohs) begin
                void'(exp_q.pop_front());
                m_words++;
            end
            if (ihs) begin
                w = ref_enc(d);
`ifdef ECC_ENC_ERR_INJECT_EN
                if (m_pend) w = w ^ m_mask;
`endif
                exp_q.push_back(w);
            end
`ifdef ECC_ENC_ERR_INJECT_EN
            if (arm) begin
                m_mask = m;
                m_pend = 1'b1;
            end else if (ihs) begin
                m_pend = 1'b0;
            end
`endif
            m_ready = (exp_q.size() < 2);
        end
        @(negedge clk);
        check_eq("in_ready", 64'(in_ready), 64'(m_ready));
        check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        check_eq("words", 64'(words), 64'(m_words));
        check_eq("inj_pending", 64'(inj_pending), 64'(m_pend));
        if (exp_q.size() > 0) begin
            check_eq("out_data", 64'(out_data), 64'(exp_q[0]));
`ifndef ECC_ENC_ERR_INJECT_EN
            check_eq("syndrome", 64'(syndrome(out_data)), 64'd0);
`endif
        end
    endtask

    initial begin
        logic [63:0] r64;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        inj_arm   = 1'b0;
        inj_mask  = '0;
        m_ready   = 1'b0;
        m_words   = '0;
        m_pend    = 1'b0;
        m_mask    = '0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b1, 32'h1234, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);

        // in_ready rises on the first edge after release
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        check_eq("ready_after_rst", 64'(in_ready), 64'd1);

        // Zero data word, then a single handshake on the output
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, '0);
        check_eq("enc_zero", 64'(out_data), 64'h2a00000000);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);
        check_eq("words_one", 64'(words), 64'd1);

        // Data word 1
        step(1'b1, 1'b1, 32'h1, 1'b0, 1'b0, '0);
        check_eq("enc_one", 64'(out_data), 64'h6900000001);
        check_eq("enc_one_syn", 64'(syndrome(out_data)), 64'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);

        // Backpressure: 3 words offered, only 2 taken
        step(1'b1, 1'b1, 32'hdeadbeef, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'hcafef00d, 1'b0, 1'b0, '0);
        check_eq("full_ready_low", 64'(in_ready), 64'd0);
        step(1'b1, 1'b1, 32'h55555555, 1'b0, 1'b0, '0);
        check_eq("full_head", 64'(out_data), 64'(ref_enc(32'hdeadbeef)));
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);
        check_eq("drain_second", 64'(out_data), 64'(ref_enc(32'hcafef00d)));
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);
        check_eq("drained", 64'(out_valid), 64'd0);

        // Sustained streaming with ready high
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, $urandom, 1'b1, 1'b0, '0);
        check_eq("stream_words", 64'(words), 64'(m_words));

        // Reset while in TWO discards buffered words
        step(1'b1, 1'b1, 32'h0badf00d, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h600dcafe, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        check_eq("rst_two_valid", 64'(out_valid), 64'd0);
        check_eq("rst_two_words", 64'(words), 64'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h00c0ffee, 1'b0, 1'b0, '0);
        check_eq("post_rst_word", 64'(out_data), 64'(ref_enc(32'h00c0ffee)));
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);

`ifdef ECC_ENC_ERR_INJECT_EN
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 39'h1);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, '0);
        check_eq("inj_single", 64'(out_data), 64'h2a00000001);
        check_eq("inj_single_cls", 64'(err_class(out_data)), 64'd1);
        check_eq("inj_cleared", 64'(inj_pending), 64'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 39'h3);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, '0);
        check_eq("inj_double_cls", 64'(err_class(out_data)), 64'd2);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0);
`endif

        // Random streaming with random backpressure and occasional arming
        for (int i = 0; i < 800; i++) begin
            r64 = {$urandom, $urandom};
            step(1'b1, ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 15) == 0), r64[38:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
